// File: rtl/pcie_pkg.sv
// Shared constants and state encoding for the PCIe read scheduler slice.
package pcie_pkg;

    localparam int BOUNDARY_BYTES = 4096;
    localparam int MAX_DW         = 1024;
    localparam int TAG_W          = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/pcie_tag_pool.sv
// PCIe tag pool: free bitmap, lowest-free selection, outstanding count and
// detection of completions that land on tags which are not allocated.
module pcie_tag_pool
    import pcie_pkg::*;
#(
    parameter int NUM_TAGS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc,
    input  logic [TAG_W-1:0] alloc_tag,
    input  logic             cpl_valid,
    input  logic [TAG_W-1:0] cpl_tag,
    input  logic             cpl_last,
    output logic             next_any,
    output logic [TAG_W-1:0] next_tag,
    output logic [8:0]       outstanding,
    output logic             err_unexpected
);

    logic [NUM_TAGS-1:0] free_q;
    logic [NUM_TAGS-1:0] free_d;
    logic [NUM_TAGS-1:0] alloc_mask;
    logic [NUM_TAGS-1:0] hit_mask;
    logic [NUM_TAGS-1:0] free_mask;
    logic                free_hit;
    logic                bad_cpl;

    // Tags beyond the pool shift out of the mask, so they never count as a hit.
    always_comb begin
        alloc_mask = alloc ? (NUM_TAGS'(1) << alloc_tag) : '0;
        hit_mask   = NUM_TAGS'(1) << cpl_tag;
        free_hit   = cpl_valid && cpl_last && (|(hit_mask & ~free_q));
        bad_cpl    = cpl_valid && cpl_last && !free_hit;
        free_mask  = free_hit ? hit_mask : '0;
        free_d     = (free_q & ~alloc_mask) | free_mask;
    end

    // Selection looks at next-cycle occupancy so a freed tag is offered one cycle later.
    always_comb begin
        next_any = |free_d;
        next_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (free_d[i]) next_tag = TAG_W'(i);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            free_q         <= '1;
            outstanding    <= '0;
            err_unexpected <= 1'b0;
        end else begin
            free_q      <= free_d;
            outstanding <= outstanding + 9'(alloc) - 9'(free_hit);
            if (bad_cpl) err_unexpected <= 1'b1;
        end
    end

endmodule

// File: rtl/pcie_read_scheduler.sv
// DMA read scheduler: splits one host read command into MRRS/4KB-bounded
// memory-read requests, tags each one, and reports done when all tags return.
//
// state | meaning
// IDLE  | waiting for a command
// ISSUE | presenting chunks to pcie_tx
// DRAIN | all chunks issued, waiting for completions
// DONE  | one-cycle done pulse
module pcie_read_scheduler
    import pcie_pkg::*;
#(
    parameter int MRRS_BYTES = 128,
    parameter int NUM_TAGS   = 32,
    parameter int LEN_W      = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [63:0]      cmd_address,
    input  logic [LEN_W-1:0] cmd_length,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [63:0]      req_address,
    output logic [9:0]       req_length_dw,
    output logic [TAG_W-1:0] req_tag,
    input  logic             cpl_valid,
    input  logic [TAG_W-1:0] cpl_tag,
    input  logic             cpl_last,
    output logic             busy,
    output logic             done,
    output logic [8:0]       outstanding,
    output logic             err_unexpected
);

    state_t           state_q, state_d;
    logic [63:0]      addr_q;
    logic [LEN_W-1:0] rem_q;
    logic [63:0]      src_addr;
    logic [LEN_W-1:0] src_rem;
    logic [63:0]      to_bound;
    logic [63:0]      limit;
    logic [63:0]      chunk;
    logic [63:0]      chunk_dw;
    logic             accept;
    logic             handshake;
    logic             load;
    logic             pool_any;
    logic [TAG_W-1:0] pool_tag;

    assign accept    = cmd_valid && cmd_ready;
    assign handshake = req_valid && req_ready;

    pcie_tag_pool #(.NUM_TAGS(NUM_TAGS)) u_pool (
        .clock         (clock),
        .reset         (reset),
        .alloc         (handshake),
        .alloc_tag     (req_tag),
        .cpl_valid     (cpl_valid),
        .cpl_tag       (cpl_tag),
        .cpl_last      (cpl_last),
        .next_any      (pool_any),
        .next_tag      (pool_tag),
        .outstanding   (outstanding),
        .err_unexpected(err_unexpected)
    );

    // The first chunk is cut straight from the command so it is presented the cycle after accept.
    always_comb begin
        src_addr = (state_q == IDLE) ? cmd_address : addr_q;
        src_rem  = (state_q == IDLE) ? cmd_length  : rem_q;
        to_bound = 64'(BOUNDARY_BYTES) - 64'(src_addr[11:0]);
        limit    = (64'(MRRS_BYTES) < to_bound) ? 64'(MRRS_BYTES) : to_bound;
        chunk    = (64'(src_rem) < limit) ? 64'(src_rem) : limit;
        chunk_dw = chunk >> 2;
        load     = pool_any &&
                   (((state_q == IDLE) && accept && (cmd_length != '0)) ||
                    ((state_q == ISSUE) && (!req_valid || req_ready) && (rem_q != '0)));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (accept) state_d = (cmd_length != '0) ? ISSUE : DONE;
            end
            ISSUE: begin
                if (handshake && (rem_q == '0)) state_d = DRAIN;
            end
            DRAIN: begin
                if (outstanding == '0) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload registers hold while the request is stalled; addr_q/rem_q track the next chunk.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q        <= '0;
            rem_q         <= '0;
            req_valid     <= 1'b0;
            req_address   <= '0;
            req_length_dw <= '0;
            req_tag       <= '0;
        end else begin
            if (accept) begin
                addr_q <= cmd_address;
                rem_q  <= cmd_length;
            end
            if (load) begin
                req_valid     <= 1'b1;
                req_address   <= src_addr;
                req_length_dw <= (chunk_dw == 64'(MAX_DW)) ? 10'd0 : 10'(chunk_dw);
                req_tag       <= pool_tag;
                addr_q        <= src_addr + chunk;
                rem_q         <= src_rem - LEN_W'(chunk);
            end else if (handshake) begin
                req_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pcie_read_scheduler.sv
// Bench for pcie_read_scheduler: directed scenarios plus random traffic,
// checked every cycle against a chunk-list / tag-set reference model.
module tb_pcie_read_scheduler;

    localparam int NT   = 32;
    localparam int MRRS = 128;
    localparam int LW   = 24;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [63:0]   cmd_address = '0;
    logic [LW-1:0] cmd_length = '0;
    logic          req_valid;
    logic          req_ready = 1'b0;
    logic [63:0]   req_address;
    logic [9:0]    req_length_dw;
    logic [7:0]    req_tag;
    logic          cpl_valid = 1'b0;
    logic [7:0]    cpl_tag = '0;
    logic          cpl_last = 1'b0;
    logic          busy;
    logic          done;
    logic [8:0]    outstanding;
    logic          err_unexpected;

    pcie_read_scheduler #(.MRRS_BYTES(MRRS), .NUM_TAGS(NT), .LEN_W(LW)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_address(cmd_address), .cmd_length(cmd_length),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_address(req_address), .req_length_dw(req_length_dw), .req_tag(req_tag),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_last(cpl_last),
        .busy(busy), .done(done), .outstanding(outstanding),
        .err_unexpected(err_unexpected)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] a;
        logic [9:0]  l;
    } chunk_t;

    typedef struct {
        logic [63:0] a;
        logic [9:0]  l;
        logic [7:0]  t;
    } req_t;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit         alloc_m[NT];
    int         cnt_m;
    bit         err_m;
    bit         busy_m;
    bit         drain_m;
    bit         exp_done, exp_done_next;
    bit         exp_rv;
    logic [7:0] exp_tag;
    bit         pres_m;
    logic [7:0] pres_tag;
    chunk_t     exp_q[$];
    req_t       hs_log[$];
    int         done_cnt;
    int         rv_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < NT; i++) if (!alloc_m[i]) return i;
        return -1;
    endfunction

    function automatic int pick_alloc();
        int lst[$];
        for (int i = 0; i < NT; i++) if (alloc_m[i]) lst.push_back(i);
        return lst[$urandom_range(0, lst.size() - 1)];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) alloc_m[i] = 1'b0;
        cnt_m = 0; err_m = 0; busy_m = 0; drain_m = 0;
        exp_done = 0; exp_done_next = 0; exp_rv = 0; pres_m = 0; pres_tag = '0;
        exp_q.delete();
    endtask

    task automatic build_chunks(input logic [63:0] addr, input longint len);
        logic [63:0] a;
        longint r, lim, to_b;
        a = addr;
        r = len;
        while (r > 0) begin
            lim  = MRRS;
            to_b = 4096 - longint'(a % 4096);
            if (to_b < lim) lim = to_b;
            if (r < lim) lim = r;
            exp_q.push_back('{a: a, l: 10'((lim / 4) % 1024)});
            a += 64'(lim);
            r -= lim;
        end
    endtask

    task automatic check();
        int lf;
        exp_done = exp_done_next;
        chk("done", done, exp_done);
        if (done) done_cnt++;
        if (req_valid) rv_cnt++;
        chk("cmd_ready", cmd_ready, !busy_m);
        chk("busy", busy, busy_m);
        chk("outstanding", outstanding, cnt_m);
        chk("err_unexpected", err_unexpected, err_m);
        lf = lowest_free();
        exp_rv = (exp_q.size() > 0) && (lf >= 0);
        chk("req_valid", req_valid, exp_rv);
        if (exp_rv) begin
            exp_tag = pres_m ? pres_tag : 8'(lf);
            chk("req_address", req_address, exp_q[0].a);
            chk("req_length_dw", req_length_dw, exp_q[0].l);
            chk("req_tag", req_tag, exp_tag);
        end
    endtask

    // Apply this cycle's events (inputs currently driven) to the model.
    task automatic update();
        bit b0, nd;
        b0 = busy_m;
        nd = drain_m && (cnt_m == 0);
        if (nd) drain_m = 0;
        exp_done_next = nd;
        if (exp_done) busy_m = 0;
        if (exp_rv && req_ready) begin
            hs_log.push_back('{a: req_address, l: req_length_dw, t: req_tag});
            alloc_m[exp_tag] = 1'b1;
            cnt_m++;
            exp_q.delete(0);
            if (exp_q.size() == 0) drain_m = 1;
            pres_m = 0;
        end else begin
            pres_m   = exp_rv;
            pres_tag = exp_tag;
        end
        if (cpl_valid && cpl_last) begin
            if (cpl_tag < NT && alloc_m[cpl_tag]) begin
                alloc_m[cpl_tag] = 1'b0;
                cnt_m--;
            end else begin
                err_m = 1;
            end
        end
        if (cmd_valid && !b0) begin
            busy_m = 1;
            build_chunks(cmd_address, longint'(cmd_length));
            if (cmd_length == 0) exp_done_next = 1;
        end
    endtask

    task automatic tick();
        update();
        @(negedge clock);
        check();
    endtask

    task automatic send_cmd(input logic [63:0] a, input logic [LW-1:0] l);
        cmd_valid = 1'b1; cmd_address = a; cmd_length = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain_all(input int budget);
        int n;
        n = 0;
        req_ready = 1'b1;
        while (busy_m && n < budget) begin
            cpl_valid = 1'b0;
            if (cnt_m > 0 && $urandom_range(0, 2) != 0) begin
                cpl_valid = 1'b1;
                cpl_tag   = 8'(pick_alloc());
                cpl_last  = ($urandom_range(0, 3) != 0);
            end
            tick();
            n++;
        end
        cpl_valid = 1'b0;
        chk("idle_after_drain", cmd_ready, 1'b1);
    endtask

    initial begin
        model_reset();
        done_cnt = 0;
        rv_cnt = 0;
        #12;
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        chk("reset_req_valid", req_valid, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        check();

        // four MRRS-sized chunks from an aligned base
        hs_log.delete(); done_cnt = 0;
        req_ready = 1'b1;
        send_cmd(64'h1000, 24'd512);
        repeat (4) tick();
        drain_all(500);
        chk("s1_count", hs_log.size(), 4);
        for (int i = 0; i < 4 && i < hs_log.size(); i++) begin
            chk("s1_addr", hs_log[i].a, 64'h1000 + 64'(i) * 64'h80);
            chk("s1_len", hs_log[i].l, 10'd32);
            chk("s1_tag", hs_log[i].t, 8'(i));
        end
        chk("s1_done_cnt", done_cnt, 1);
        chk("s1_outstanding", outstanding, 9'd0);

        // chunk split at a 4 KB boundary
        hs_log.delete();
        send_cmd(64'h0FF8, 24'd16);
        drain_all(500);
        chk("s2_count", hs_log.size(), 2);
        if (hs_log.size() == 2) begin
            chk("s2_addr0", hs_log[0].a, 64'h0FF8);
            chk("s2_len0", hs_log[0].l, 10'd2);
            chk("s2_addr1", hs_log[1].a, 64'h1000);
            chk("s2_len1", hs_log[1].l, 10'd2);
        end

        // stalled request keeps its payload and allocates nothing
        req_ready = 1'b0;
        send_cmd(64'h2000, 24'd256);
        repeat (5) begin
            chk("hold_valid", req_valid, 1'b1);
            chk("hold_addr", req_address, 64'h2000);
            chk("hold_tag", req_tag, 8'd0);
            chk("hold_outs", outstanding, 9'd0);
            tick();
        end
        drain_all(500);

        // zero-length command, then a stray completion while idle
        rv_cnt = 0; done_cnt = 0;
        send_cmd(64'h5000, 24'd0);
        chk("zero_done", done, 1'b1);
        tick();
        tick();
        chk("zero_no_req", rv_cnt, 0);
        chk("zero_done_cnt", done_cnt, 1);
        cpl_valid = 1'b1; cpl_tag = 8'd7; cpl_last = 1'b1;
        tick();
        cpl_valid = 1'b0;
        chk("stray_err", err_unexpected, 1'b1);
        chk("stray_outs", outstanding, 9'd0);

        // pool exhaustion and refill of a freed tag
        send_cmd(64'h0, 24'd8192);
        repeat (36) tick();
        chk("exh_outs", outstanding, 9'd32);
        chk("exh_valid", req_valid, 1'b0);
        hs_log.delete();
        cpl_valid = 1'b1; cpl_tag = 8'd1; cpl_last = 1'b1;
        tick();
        cpl_valid = 1'b0;
        chk("refill_valid", req_valid, 1'b1);
        tick();
        chk("refill_count", hs_log.size(), 1);
        if (hs_log.size() > 0) chk("refill_tag", hs_log[0].t, 8'd1);
        drain_all(3000);

        // reset while draining with three tags outstanding
        send_cmd(64'h3000, 24'd384);
        repeat (5) tick();
        chk("pre_reset_outs", outstanding, 9'd3);
        #2 reset = 1'b1;
        #1;
        chk("rst_outs", outstanding, 9'd0);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_addr", req_address, 64'h0);
        chk("rst_len", req_length_dw, 10'd0);
        chk("rst_tag", req_tag, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_err", err_unexpected, 1'b0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        check();
        cpl_valid = 1'b1; cpl_tag = 8'd1; cpl_last = 1'b1;
        tick();
        cpl_valid = 1'b0;
        chk("late_cpl_err", err_unexpected, 1'b1);
        hs_log.delete();
        send_cmd(64'h4000, 24'd128);
        tick();
        chk("post_reset_count", hs_log.size(), 1);
        if (hs_log.size() > 0) chk("post_reset_tag", hs_log[0].t, 8'd0);
        drain_all(500);

        // random traffic, including commands offered while busy
        for (int c = 0; c < 3000; c++) begin
            logic [63:0] a;
            req_ready = ($urandom_range(0, 3) != 0);
            cmd_valid = ($urandom_range(0, 7) == 0);
            a = {32'($urandom), 32'($urandom)};
            a[2:0] = 3'd0;
            if ($urandom_range(0, 1) == 1) a[11:0] = 12'hFF8 - 12'(8 * $urandom_range(0, 40));
            cmd_address = a;
            cmd_length  = LW'(8 * $urandom_range(0, 160));
            cpl_valid = 1'b0;
            if (cnt_m > 0 && $urandom_range(0, 2) == 0) begin
                cpl_valid = 1'b1;
                cpl_tag   = 8'(pick_alloc());
                cpl_last  = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        cmd_valid = 1'b0;
        drain_all(5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pcie_read_scheduler.md
Name: pcie_read_scheduler

Overview:
- DMA read controller placed in front of the read-request channel of pcie_tx.
- Accepts one host-memory read command (address and length) at a time.
- Splits the command into memory-read requests that respect the max read request size and never cross a 4 KB boundary.
- Allocates a PCIe tag to each request, frees the tag when its final completion arrives, and signals done once every tag has been returned.

Parameters:
- MRRS_BYTES, 128: max read request size in bytes; power of 2, range 64..4096.
- NUM_TAGS, 32: outstanding-tag pool size; power of 2, range 1..256.
- LEN_W, 24: width of the command byte-length field.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_address  in  64  byte address; bits [2:0] must be 0.
- cmd_length  in  LEN_W  byte count; multiple of 8, may be 0.
- req_valid  out  1  read request to pcie_tx.
- req_ready  in  1  pcie_tx accepts the request.
- req_address  out  64  request byte address.
- req_length_dw  out  10  request length in DW (1024 encoded as 0).
- req_tag  out  8  allocated tag.
- cpl_valid  in  1  completion TLP for cpl_tag seen by the RX parser.
- cpl_tag  in  8  tag of that completion.
- cpl_last  in  1  this completion finishes the request (byte count reached).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a command fully completes.
- outstanding  out  9  number of allocated tags.
- err_unexpected  out  1  sticky; a completion arrived for a tag that is not allocated.

Behaviour:
- Reset (async assert, sync release): state IDLE; every tag free; req_valid=0; done=0; outstanding=0; err_unexpected=0; cmd_ready=1; address/length/tag outputs 0.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch address and remaining length. Go to ISSUE if length != 0, otherwise DONE.
  - ISSUE: present one chunk per request.
    - Chunk = min(remaining, MRRS_BYTES, 4096 - address[11:0]).
    - req_valid is asserted only while a free tag exists.
    - Payload (address, length, tag) is registered and stays stable while req_valid && !req_ready.
    - On handshake: mark the tag allocated, address += chunk, remaining -= chunk. The next chunk is presented in the following cycle, so back-to-back throughput is one request per cycle.
    - When remaining reaches 0 after a handshake, go to DRAIN.
  - DRAIN: req_valid=0. When outstanding==0, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency:
  - First req_valid appears one cycle after the command handshake.
  - Zero-length command: done pulses one cycle after the command handshake, and no request is issued.
- Tag selection:
  - Lowest-numbered free tag.
  - A tag freed in cycle N is allocatable in cycle N+1, never in the same cycle.
- Completions:
  - cpl_valid && cpl_last on an allocated tag frees it.
  - cpl_valid without cpl_last has no effect.
  - cpl_valid && cpl_last on a free tag, or on cpl_tag >= NUM_TAGS: ignored, err_unexpected set (cleared only by reset).
  - Completions are processed in every state.
- outstanding = allocations - frees for the cycle; a simultaneous allocate and free leaves it unchanged.
- Pool exhausted in ISSUE: req_valid drops once the last free tag is consumed, and reasserts the cycle after any free.
- Reset mid-operation clears every tag immediately; late completions after reset flag err_unexpected.
- Widths:
  - Address arithmetic is 64-bit modulo; wrap is not checked.
  - Chunk length in DW = bytes >> 2; the value 1024 DW is encoded as 10'd0.
- cmd_ready=0 outside IDLE; a command presented then is held off and not accepted.

Decomposition:
- Shared package pcie_pkg holds:
  - localparams for the 4 KB boundary (4096) and max DW length (1024).
  - tag width of 8.
  - state encoding constants: IDLE=0, ISSUE=1, DRAIN=2, DONE=3.
- Sub-module pcie_tag_pool:
  - NUM_TAGS-bit free bitmap, lowest-set priority encoder, alloc/free ports, outstanding counter, unexpected-free detection.
  - Keeps the parent to the FSM plus chunk arithmetic.

Test Plan:
- cmd_address=0x1000, cmd_length=512, req_ready=1 -> four requests:
  - addresses 0x1000, 0x1080, 0x1100, 0x1180; length_dw=32 each; tags 0,1,2,3 on consecutive cycles.
  - Completions with cpl_last for tags 0..3 -> done pulse once; outstanding back to 0.
- cmd_address=0x0FF8, cmd_length=16 -> request 0x0FF8 with 2 DW, then 0x1000 with 2 DW (4 KB split).
- NUM_TAGS=2, length 512, no completions -> exactly two requests (tags 0,1), then req_valid=0.
  - Completion for tag 1 -> next request carries tag 1 one cycle later.
- req_ready held low for 5 cycles -> req_valid held high with address, length and tag unchanged; no allocation until the handshake.
- cmd_length=0 -> no req_valid; done pulses one cycle after the command handshake.
  - cpl_valid && cpl_last with tag 7 while idle -> err_unexpected=1 and outstanding unchanged.
- reset asserted mid-DRAIN with outstanding=3 -> outputs zero asynchronously.
  - After release, cmd_ready=1, and a new command allocates tag 0 first.
